// File: rtl/predistort_pkg.sv
// Shared definitions for the predistorter tap-table scheduler: register map,
// readback layout and FSM state encoding.
package predistort_pkg;

  localparam int REG_ADDR_OFF   = 0;
  localparam int REG_DATA_OFF   = 1;
  localparam int REG_COMMIT_OFF = 2;

  localparam logic [7:0] RB_STATUS_ADDR = 8'd0;
  localparam int RB_BUSY_BIT    = 0;
  localparam int RB_PENDING_LSB = 16;
  localparam int RB_DROP_LSB    = 32;
  localparam int RB_DONE_LSB    = 48;

  localparam logic [63:0] BAD_RB = 64'hBEEE_EEEE_EEEE_EEEF;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND
  } state_t;

endpackage

// File: rtl/ram_2port.sv
// Simple dual-port table RAM: one write port, one read port with a single
// registered read stage.
module ram_2port #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset (it maps onto block RAM);
  // only the read register is, so the output is defined from reset onward.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/predistort_tap_sched.sv
// Stages one tap table from the settings bus and streams it round-robin to each
// committed predistorter channel. Define PREDISTORT_TAP_SCHED_STATS_EN for counters.
module predistort_tap_sched
  import predistort_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int WIDTH        = 16,
  parameter int NUM_TAPS     = 256,
  parameter int SR_TAP_BASE  = 129
) (
  input  logic                    ce_clk,
  input  logic                    ce_rst,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [7:0]              rb_addr,
  output logic [63:0]             rb_data,
  output logic [WIDTH-1:0]        taps_tdata,
  output logic                    taps_tlast,
  output logic [NUM_CHANNELS-1:0] taps_tvalid,
  input  logic [NUM_CHANNELS-1:0] taps_tready,
  output logic                    busy
);

  localparam int PTR_W = $clog2(NUM_TAPS);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_TAPS - 1);
  localparam logic [7:0]       ADDR_REG   = 8'(SR_TAP_BASE + REG_ADDR_OFF);
  localparam logic [7:0]       DATA_REG   = 8'(SR_TAP_BASE + REG_DATA_OFF);
  localparam logic [7:0]       COMMIT_REG = 8'(SR_TAP_BASE + REG_COMMIT_OFF);

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d, commit_mask, served_mask;
  logic [CH_W-1:0]         cur_q, last_served_q, pick;
  logic                    start, advance, finish, ram_re;
  logic                    addr_wr, data_wr, commit_wr, data_accept;
  logic [15:0]             done_cnt, drop_cnt;
  logic [63:0]             rb_status;
  logic                    unused_set_data;

  assign addr_wr     = set_stb && (set_addr == ADDR_REG);
  assign data_wr     = set_stb && (set_addr == DATA_REG);
  assign commit_wr   = set_stb && (set_addr == COMMIT_REG);
  assign data_accept = data_wr && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign unused_set_data = ^set_data;

  // Round-robin pick: first pending channel strictly after the last one served.
  always_comb begin
    pick = last_served_q;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      if (pending_q[CH_W'((int'(last_served_q) + i) % NUM_CHANNELS)])
        pick = CH_W'((int'(last_served_q) + i) % NUM_CHANNELS);
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    ram_re      = 1'b0;
    taps_tvalid = '0;
    taps_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          start   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        ram_re  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        taps_tvalid[cur_q] = 1'b1;
        taps_tlast         = (rd_ptr_q == LAST_PTR);
        if (taps_tready[cur_q]) begin
          if (taps_tlast) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A commit landing on the final handshake re-arms the channel just served.
  always_comb begin
    commit_mask        = commit_wr ? set_data[NUM_CHANNELS-1:0] : '0;
    served_mask        = '0;
    served_mask[cur_q] = finish;
    pending_d          = (pending_q & ~served_mask) | commit_mask;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pending_q     <= '0;
      cur_q         <= '0;
      last_served_q <= CH_W'(NUM_CHANNELS - 1);
    end else begin
      pending_q <= pending_d;
      if (addr_wr)          wr_ptr_q <= set_data[PTR_W-1:0];
      else if (data_accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (start) begin
        cur_q    <= pick;
        rd_ptr_q <= '0;
      end
      if (advance) rd_ptr_q      <= rd_ptr_q + PTR_W'(1);
      if (finish)  last_served_q <= cur_q;
    end
  end

  ram_2port #(
    .DEPTH (NUM_TAPS),
    .WIDTH (WIDTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (ce_clk),
    .rst   (ce_rst),
    .we    (data_accept),
    .waddr (wr_ptr_q),
    .wdata (set_data[WIDTH-1:0]),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (taps_tdata)
  );

`ifdef PREDISTORT_TAP_SCHED_STATS_EN
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      done_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (finish) done_cnt <= done_cnt + 16'd1;
      if (data_wr && busy && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign done_cnt = '0;
  assign drop_cnt = '0;
`endif

  always_comb begin
    rb_status                          = '0;
    rb_status[RB_BUSY_BIT]             = busy;
    rb_status[RB_PENDING_LSB +: 16]    = 16'(pending_q);
    rb_status[RB_DROP_LSB +: 16]       = drop_cnt;
    rb_status[RB_DONE_LSB +: 16]       = done_cnt;
    rb_data = (rb_addr == RB_STATUS_ADDR) ? rb_status : BAD_RB;
  end

endmodule

// File: doc/predistort_tap_sched.md
# predistort_tap_sched

Tap-table load controller for the four-channel predistorter block. It takes settings-bus writes in the compute-engine clock domain and stages one tap table in a local RAM. On command, it streams that table into the tap AXI-stream port of each selected predistorter channel, one channel at a time, in round-robin order. It sits between the noc_shell settings bus and the per-channel predistort tap inputs, and replaces the per-channel config FIFOs.

## Interface
Parameters:
- NUM_CHANNELS, 4: number of predistorter channels served.
- WIDTH, 16: tap word width.
- NUM_TAPS, 256: table length; power of two, at least 2.
- SR_TAP_BASE, 129: base settings address. Registers are ADDR=base, DATA=base+1, COMMIT=base+2.

Ports:
- ce_clk, in, 1: compute-engine clock; the only clock.
- ce_rst, in, 1: reset; synchronous, active-high.
- set_stb, in, 1: settings write strobe.
- set_addr, in, 8: settings address.
- set_data, in, 32: settings data.
- rb_addr, in, 8: readback address.
- rb_data, out, 64: readback data; combinational from registers.
- taps_tdata, out, WIDTH: tap word, shared by all channels.
- taps_tlast, out, 1: marks the last tap of a table; shared.
- taps_tvalid, out, NUM_CHANNELS: one-hot valid for the selected channel.
- taps_tready, in, NUM_CHANNELS: per-channel ready.
- busy, out, 1: high whenever the state is not IDLE.

## Operation
- ADDR write: wr_ptr <= set_data[log2(NUM_TAPS)-1:0].
- DATA write:
  - In IDLE: RAM[wr_ptr] <= set_data[WIDTH-1:0], and wr_ptr increments. wr_ptr wraps from NUM_TAPS-1 to 0.
  - When busy: the write is dropped and wr_ptr is unchanged.
- COMMIT write: pending <= pending | set_data[NUM_CHANNELS-1:0]. Commits are accepted in any state.
- State machine:
  - IDLE: if pending != 0, latch cur = the first set bit strictly after last_served, wrapping around; set rd_ptr = 0; go to READ.
  - READ: issue a RAM read at rd_ptr; go to SEND.
  - SEND: drive taps_tvalid[cur] = 1 with the registered RAM data; taps_tlast = (rd_ptr == NUM_TAPS-1).
    - On taps_tready[cur] with not last: rd_ptr++ and go to READ.
    - On taps_tready[cur] with last: pending[cur] <= COMMIT bit for cur in this same cycle (a simultaneous re-commit wins); last_served <= cur; go to IDLE.
- Output data and valid are held stable while tready is low. Valid never drops without a handshake.
- last_served resets to NUM_CHANNELS-1, so channel 0 is served first.
- Readback at rb_addr 0: {done_cnt[15:0], drop_cnt[15:0], pending zero-extended to 16 bits, 15'b0, busy}. Any other address returns 64'hBEEEEEEEEEEEEEEF.
  - done_cnt increments once per completed table and wraps.
  - drop_cnt counts dropped DATA writes and saturates at 0xFFFF.

## Timing
- Reset values: taps_tvalid = 0, taps_tlast = 0, taps_tdata = 0, busy = 0, state = IDLE, pending = 0, wr_ptr = rd_ptr = 0, both counters = 0. RAM contents are undefined.
- Commit strobe sampled at edge k: pending updates at edge k; READ at edge k+1; taps_tvalid is high after edge k+2.
- Throughput is one tap per two cycles at best. A table takes 2·NUM_TAPS cycles plus stall cycles.
- A DATA write in the same cycle that IDLE leaves for READ is accepted, and the first read observes it.
- Reset mid-table: all outputs are low after the next edge and the partial table is abandoned. The predistorters share ce_rst and discard their partial state.
- Empty pending mask: the FSM remains in IDLE. A commit of all zeros has no effect.

## Configuration
- PREDISTORT_TAP_SCHED_STATS_EN defined: done_cnt and drop_cnt are implemented and reported as above.
- Not defined: both counters are removed and their readback fields read 0. Dropping DATA writes while busy is unchanged.

## Structure
- predistort_pkg holds:
  - the register offsets (ADDR/DATA/COMMIT);
  - the readback address and field positions;
  - the state enum (IDLE, READ, SEND);
  - the BAD_RB constant 64'hBEEEEEEEEEEEEEEF.
- Sub-module ram_2port (NUM_TAPS×WIDTH, 1-cycle registered read): write port from the settings logic, read port from the FSM.

## Test plan
- Write ADDR=0, then DATA 0..255 as values 0x1000+i, then COMMIT=0x1. Required: channel 0 receives 256 beats 0x1000..0x10FF, tlast on beat 255 only, and done_cnt=1.
- COMMIT=0xF with all tready high. Required: channels are served in order 0,1,2,3; each receives the identical table; busy falls after the last tlast; done_cnt=4.
- COMMIT=0x1; during the channel-0 stream, issue COMMIT=0x1 in the last-handshake cycle. Required: channel 0 is reloaded a second time and pending=0 at the end.
- Three DATA writes while busy. Required: RAM and wr_ptr are unchanged and drop_cnt=3. Without the macro, the readback field reads 0.
- Hold taps_tready[2] low for 10 cycles mid-table. Required: tdata, tlast and tvalid are stable throughout, and no beat is lost or duplicated.
- Assert ce_rst at beat 100 of channel 1. Required: the next cycle has tvalid=0, pending=0, busy=0, and readback of 0 reports all fields zero.
